imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the decode stage.
//  - Decodes the opcode internally from instr[6:0]; there is no separate opcode input.
//  - Adds U-type, shift-amount and CSR-zimm formats, XLEN=64 support and an illegal-format flag.
//  - Uses a valid/ready handshake with a 2-entry skid buffer.
//  - Sits between fetch/decode and register-read; one result per cycle.
// PARAMETERS
//  XLEN       32  result width; legal values are 32 or 64
//  SUPPORT_U   1  1: LUI/AUIPC decoded; 0: those opcodes are illegal
//  SUPPORT_Z   0  1: SYSTEM opcode with funct3[2]=1 yields zimm; 0: SYSTEM is illegal
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  flush        in   1     synchronous pipeline flush
//  in_valid     in   1     in_instr valid
//  in_ready     out  1     block can accept input (registered)
//  in_instr     in   32    full instruction word
//  out_valid    out  1     out_* valid
//  out_ready    in   1     consumer accepts out_*
//  out_imm      out  XLEN  sign/zero-extended immediate
//  out_fmt      out  3     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 ZIMM, 7 SHAMT
//  out_illegal  out  1     opcode not supported by this configuration
// BEHAVIOUR
//  Reset (async on rst_n low):
//   - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, in_ready=1.
//   - Both buffer entries are empty.
//  Formats, with sx() meaning sign-extend to XLEN:
//   - I: 0000011, 0010011, 1100111, and 0011011 when XLEN=64 -> sx(i[31:20]).
//   - SHAMT: 0010011 with funct3 001 or 101 -> zero-extended i[24:20] (XLEN=32) or i[25:20] (XLEN=64).
//     Funct7 bits are discarded. 0011011 shifts always use i[24:20].
//   - S: 0100011 -> sx({i[31:25], i[11:7]}).
//   - B: 1100011 -> sx({i[31], i[7], i[30:25], i[11:8], 1'b0}).
//   - J: 1101111 -> sx({i[31], i[19:12], i[20], i[30:21], 1'b0}).
//   - U: 0110111, 0010111 -> sx({i[31:12], 12'b0}); upper bits replicate i[31] when XLEN=64.
//   - ZIMM: 1110011 with funct3[2]=1 -> zero-extended i[19:15].
//   - Anything else, or a disabled format -> out_imm=0, out_fmt=0, out_illegal=1.
//   - Illegal entries still flow through the handshake.
//  Handshake:
//   - A transfer occurs on valid&ready at each side.
//   - Latency is 1 cycle from input accept to out_valid when the pipeline is empty.
//   - Throughput is 1 per cycle while out_ready=1.
//   - Storage: output register plus one skid entry.
//   - in_ready depends only on registered state: it is 0 exactly when both entries are full.
//   - There is no combinational path from out_ready to in_ready.
//   - While out_valid=1 and out_ready=0, all out_* stay stable.
//   - Order is preserved; no entry is dropped or duplicated.
//   - Simultaneous accept and drain when full: the skid entry moves to the output; the new input fills the skid.
//   - in_valid while in_ready=0 is ignored; the producer must hold it.
//  Flush:
//   - Both entries are empty after the edge; out_valid=0, in_ready=1 next cycle.
//   - An input presented in the flush cycle is discarded.
//   - flush has priority over accept and drain.
//  Reset mid-operation:
//   - In-flight entries are lost; outputs return to reset values immediately (asynchronous).
// TESTING
//  - ADDI 0xFFF00093, XLEN=32, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0.
//  - BEQ 0xFE000EE3 -> out_imm=0xFFFFFFFC, fmt=3.
//  - SRAI 0x4030D093 -> out_imm=0x00000003, fmt=7.
//  - LUI 0x800000B7, XLEN=64 -> out_imm=0xFFFFFFFF80000000, fmt=4.
//  - LUI 0x123450B7, XLEN=64 -> out_imm=0x0000000012345000, fmt=4.
//  - 0x0000007F -> illegal=1, imm=0, fmt=0.
//  - SUPPORT_U=0 with LUI -> illegal=1.
//  - Backpressure: out_ready=0, 3 back-to-back valid inputs A, B, C.
//    - A and B are accepted; in_ready=0 from the cycle after B; C is held.
//    - Raise out_ready -> A, B, C appear on consecutive cycles; out_* stable while stalled.
//  - Flush with 2 entries held and in_valid=1 -> next cycle out_valid=0, in_ready=1; nothing from before the flush emerges.
//  - rst_n pulsed low mid-stream -> all outputs are reset values while low; the first post-reset input returns in 1 cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes instr[6:0] and emits the
// extended immediate, format and illegal flag through a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int SUPPORT_U = 1,
  parameter int SUPPORT_Z = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam bit X64 = (XLEN == 64);

  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_Z  = 3'd6;
  localparam logic [2:0] FMT_SH = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       sh_f3;
  logic       is_op, is_op32;
  logic       is_i, is_sh, is_s, is_b, is_j, is_u, is_z;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign sh_f3 = (f3 == 3'b001) | (f3 == 3'b101);

  assign is_op   = (opc == 7'b0010011);
  assign is_op32 = X64 && (opc == 7'b0011011);
  assign is_sh   = (is_op | is_op32) & sh_f3;
  assign is_i    = (opc == 7'b0000011) | (opc == 7'b1100111)
                 | ((is_op | is_op32) & ~sh_f3);
  assign is_s    = (opc == 7'b0100011);
  assign is_b    = (opc == 7'b1100011);
  assign is_j    = (opc == 7'b1101111);
  assign is_u    = (SUPPORT_U != 0)
                 && ((opc == 7'b0110111) || (opc == 7'b0010111));
  assign is_z    = (SUPPORT_Z != 0)
                 && (opc == 7'b1110011) && f3[2];

  ent_t dec;

  always_comb begin
    dec     = '0;
    dec.ill = 1'b1;
    unique case (1'b1)
      is_i: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      is_sh: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_SH;
        // 32-bit word shifts keep a 5-bit shamt even on RV64
        dec.imm = (X64 && !is_op32) ? XLEN'(in_instr[25:20])
                                    : XLEN'(in_instr[24:20]);
      end
      is_s: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      is_b: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0}));
      end
      is_j: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0}));
      end
      is_u: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      is_z: begin
        dec.ill = 1'b0;
        dec.fmt = FMT_Z;
        dec.imm = XLEN'(in_instr[19:15]);
      end
      default: ;
    endcase
  end

  ent_t out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic acc, drain;

  assign in_ready = ~(out_v_q & skid_v_q);
  assign acc      = in_valid & in_ready;
  assign drain    = out_v_q & out_ready;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || drain) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = acc;
        if (acc) skid_d = dec;
      end else begin
        out_v_d = acc;
        if (acc) out_d = dec;
      end
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d   = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid   = out_v_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations share one handshake,
// directed corner cases then random traffic against a queue model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0;

  logic        a_ir, a_ov, a_il;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic        b_ir, b_ov, b_il;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic        c_ir, c_ov, c_il;
  logic [31:0] c_imm;
  logic [2:0]  c_fmt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SUPPORT_U(1), .SUPPORT_Z(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ir), .in_instr(in_instr),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_il));

  imm_gen_pipe #(.XLEN(64), .SUPPORT_U(1), .SUPPORT_Z(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_ir), .in_instr(in_instr),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_il));

  imm_gen_pipe #(.XLEN(32), .SUPPORT_U(0), .SUPPORT_Z(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_ir), .in_instr(in_instr),
    .out_valid(c_ov), .out_ready(out_ready),
    .out_imm(c_imm), .out_fmt(c_fmt), .out_illegal(c_il));

  // Reference: {illegal, fmt, imm64} straight from the encoding rules
  function automatic logic [67:0] model(logic [31:0] i, bit x64,
                                        bit su, bit sz);
    longint s, u, imm;
    logic [2:0] fmt, f3;
    bit ill;
    s = longint'($signed(i));
    u = longint'({32'b0, i});
    f3 = i[14:12];
    ill = 0; fmt = 0; imm = 0;
    case (i[6:0])
      7'h03, 7'h67: begin fmt = 1; imm = s >>> 20; end
      7'h13:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 7; imm = (u >> 20) & (x64 ? 63 : 31);
        end else begin
          fmt = 1; imm = s >>> 20;
        end
      7'h1b:
        if (!x64) ill = 1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 7; imm = (u >> 20) & 31;
        end else begin
          fmt = 1; imm = s >>> 20;
        end
      7'h23: begin
        fmt = 2;
        imm = ((s >>> 25) << 5) | ((u >> 7) & 31);
      end
      7'h63: begin
        fmt = 3;
        imm = ((s >>> 31) << 12) | (((u >> 7) & 1) << 11)
            | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      end
      7'h6f: begin
        fmt = 5;
        imm = ((s >>> 31) << 20) | (((u >> 12) & 255) << 12)
            | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      end
      7'h37, 7'h17:
        if (su) begin fmt = 4; imm = s & ~64'hFFF; end
        else ill = 1;
      7'h73:
        if (sz && f3[2]) begin fmt = 6; imm = (u >> 15) & 31; end
        else ill = 1;
      default: ill = 1;
    endcase
    if (ill) begin fmt = 0; imm = 0; end
    if (!x64) imm = imm & 64'hFFFF_FFFF;
    return {ill, fmt, 64'(imm)};
  endfunction

  function automatic logic [67:0] got(int k);
    case (k)
      0: return {a_il, a_fmt, 32'b0, a_imm};
      1: return {b_il, b_fmt, b_imm};
      default: return {c_il, c_fmt, 32'b0, c_imm};
    endcase
  endfunction

  function automatic logic [67:0] exp_of(int k, logic [31:0] i);
    return model(i, k == 1, k != 2, k == 1);
  endfunction

  task automatic chk(string tag, logic [67:0] obs, logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_a"}, {a_ov, a_ir, got(0)}, {2'b01, 68'h0});
    chk({tag, "_b"}, {b_ov, b_ir, got(1)}, {2'b01, 68'h0});
    chk({tag, "_c"}, {c_ov, c_ir, got(2)}, {2'b01, 68'h0});
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h1b, 7'h23,
                           7'h63, 7'h6f, 7'h37, 7'h17, 7'h73};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = ops[k];
    return r;
  endfunction

  logic [31:0] q [$];
  logic [67:0] saved [3];
  bit stall_prev = 0;
  bit hold = 0;

  task automatic rcycle(bit rnd);
    bit acc, drain;
    if (rnd) begin
      if (!hold) begin
        in_valid = ($urandom % 4) != 0;
        in_instr = rnd_instr();
      end
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
    end else begin
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("occ_valid", 68'({a_ov, b_ov, c_ov}), {3{q.size() > 0}});
    chk("occ_ready", 68'({a_ir, b_ir, c_ir}), {3{q.size() < 2}});
    if (stall_prev)
      for (int k = 0; k < 3; k++) chk("stable", got(k), saved[k]);
    drain = a_ov && out_ready;
    if (drain && q.size() > 0)
      for (int k = 0; k < 3; k++) chk("drain", got(k), exp_of(k, q[0]));
    stall_prev = a_ov && !out_ready && !flush;
    for (int k = 0; k < 3; k++) saved[k] = got(k);
    acc = in_valid && a_ir && !flush;
    hold = in_valid && !a_ir && !flush;
    if (flush) q.delete();
    else begin
      if (drain && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(in_instr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();

    send_one(32'hFFF00093);
    chk("addi", {a_ov, got(0)}, {1'b1, 1'b0, 3'd1, 64'hFFFF_FFFF});
    send_one(32'hFE000EE3);
    chk("beq", got(0), {1'b0, 3'd3, 64'hFFFF_FFFC});
    send_one(32'h4030D093);
    chk("srai32", got(0), {1'b0, 3'd7, 64'h3});
    chk("srai64", got(1), {1'b0, 3'd7, 64'h3});
    send_one(32'h800000B7);
    chk("lui64n", got(1), {1'b0, 3'd4, 64'hFFFF_FFFF_8000_0000});
    chk("lui32n", got(0), {1'b0, 3'd4, 64'h8000_0000});
    chk("lui_nou", got(2), {1'b1, 3'd0, 64'h0});
    send_one(32'h123450B7);
    chk("lui64p", got(1), {1'b0, 3'd4, 64'h1234_5000});
    send_one(32'h0000007F);
    chk("bad_op", got(0), {1'b1, 3'd0, 64'h0});
    send_one(32'h3401D073);
    chk("zimm64", got(1), {1'b0, 3'd6, 64'h3});
    chk("zimm_off", got(0), {1'b1, 3'd0, 64'h0});
    tick();
    chk("drained", 68'(a_ov), 68'(0));

    // Backpressure: A, B accepted, C held until space frees
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    tick();
    chk("bp_a_rdy", 68'({a_ov, a_ir}), 68'(2'b11));
    in_instr = 32'h00200093;
    tick();
    chk("bp_full", 68'({a_ov, a_ir}), 68'(2'b10));
    in_instr = 32'h00300093;
    tick();
    chk("bp_hold", {a_ir, got(0)}, {1'b0, 1'b0, 3'd1, 64'h1});
    out_ready = 1'b1;
    #1;
    chk("bp_out_a", got(0), {1'b0, 3'd1, 64'h1});
    tick();
    chk("bp_out_b", {a_ov, got(0)}, {1'b1, 1'b0, 3'd1, 64'h2});
    tick();
    in_valid = 1'b0;
    chk("bp_out_c", {a_ov, got(0)}, {1'b1, 1'b0, 3'd1, 64'h3});
    tick();
    chk("bp_empty", 68'(a_ov), 68'(0));

    // Flush with both entries held and a new input offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00400093;
    tick();
    in_instr = 32'h00500093;
    tick();
    in_instr = 32'h00600093;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_state", 68'({a_ov, a_ir, b_ov, c_ov}), 68'(4'b0100));
    out_ready = 1'b1;
    tick();
    tick();
    chk("fl_nothing", 68'({a_ov, b_ov, c_ov}), 68'(0));

    // Asynchronous reset with entries in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00700093;
    tick();
    in_instr = 32'h00800093;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    tick();
    chk_reset("rst_hold");
    #2;
    rst_n = 1'b1;
    tick();
    send_one(32'hFFC10113);
    chk("rst_after", {a_ov, got(0)}, {1'b1, 1'b0, 3'd1, 64'hFFFF_FFFC});
    tick();

    for (int n = 0; n < 600; n++) rcycle(1'b1);
    hold = 0;
    for (int n = 0; n < 4; n++) rcycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
